// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and the per-axis phase type.
package vga_timing_pkg;

  localparam int unsigned CNT_W         = 11;
  localparam int unsigned CNT_MAX_TOTAL = 2048;
  localparam int unsigned FRAME_CNT_W   = 16;

  // 1024x768@60, 65 MHz pixel clock
  localparam int unsigned DEF_H_ACTIVE = 1024;
  localparam int unsigned DEF_H_FP     = 24;
  localparam int unsigned DEF_H_SYNC   = 136;
  localparam int unsigned DEF_H_BP     = 160;
  localparam int unsigned DEF_V_ACTIVE = 768;
  localparam int unsigned DEF_V_FP     = 3;
  localparam int unsigned DEF_V_SYNC   = 6;
  localparam int unsigned DEF_V_BP     = 29;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus ACTIVE/FRONT/SYNC/BACK phase tracker.
// blank/sync are derived from the next count so they line up with the count register.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter bit          POL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic             wrap,
  output logic [CNT_W-1:0] count,
  output logic             blank,
  output logic             sync
);

  localparam int unsigned      TOTAL    = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_AT  = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(ACTIVE + FP + SYNC);

  // Reject timings that overflow the counter or collapse a phase to nothing
  if (TOTAL > CNT_MAX_TOTAL || ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_timing
    $error("vga_axis_counter: illegal timing parameters");
  end

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] count_d;
  logic             blank_d;
  logic             sync_d;

  // Phase state register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_ACTIVE;
      count   <= '0;
      blank   <= 1'b0;
      sync    <= ~POL;
    end else begin
      phase_q <= phase_d;
      count   <= count_d;
      blank   <= blank_d;
      sync    <= sync_d;
    end
  end

  // Next count, next phase and the outputs that describe that next count
  always_comb begin
    phase_d = phase_q;
    count_d = count;
    wrap    = 1'b0;
    if (inc) begin
      wrap    = (count == LAST);
      count_d = wrap ? '0 : count + CNT_W'(1);
      case (phase_q)
        PH_ACTIVE: if (count_d == FRONT_AT) phase_d = PH_FRONT;
        PH_FRONT:  if (count_d == SYNC_AT)  phase_d = PH_SYNC;
        PH_SYNC:   if (count_d == BACK_AT)  phase_d = PH_BACK;
        PH_BACK:   if (count_d == '0)       phase_d = PH_ACTIVE;
        default:                            phase_d = PH_ACTIVE;
      endcase
    end
    blank_d = (phase_d != PH_ACTIVE);
    sync_d  = (phase_d == PH_SYNC) ? POL : ~POL;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: cascaded horizontal/vertical axis counters plus
// line/frame pulses and a completed-frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic [CNT_W-1:0]       hcount,
  output logic [CNT_W-1:0]       vcount,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   hblank,
  output logic                   vblank,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  logic h_wrap;
  logic v_wrap;
  logic v_inc;

  assign v_inc = en & h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL)
  ) u_h_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (en),
    .wrap  (h_wrap),
    .count (hcount),
    .blank (hblank),
    .sync  (hsync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL)
  ) u_v_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (v_inc),
    .wrap  (v_wrap),
    .count (vcount),
    .blank (vblank),
    .sync  (vsync)
  );

  // Line/frame pulses coincide with the counts returning to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
      if (h_wrap & v_wrap) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: driver predicts each cycle's outputs from a raster model,
// per-instance monitors pop and compare. Instance 0 uses default 1024x768
// timing, instance 1 a tiny positive-polarity timing so whole frames fit.
module tb_vga_timing_gen;

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit hb;
    bit vb;
    bit ls;
    bit fs;
    int fc;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d_n = 1'b0;
  logic rst_s_n = 1'b0;
  logic en_d = 1'b0;
  logic en_s = 1'b0;

  logic [10:0] hcount_d, vcount_d, hcount_s, vcount_s;
  logic        hsync_d, vsync_d, hblank_d, vblank_d, ls_d, fs_d;
  logic        hsync_s, vsync_s, hblank_s, vblank_s, ls_s, fs_s;
  logic [15:0] fc_d, fc_s;

  vga_timing_gen u_dut_def (
    .clk         (clk),
    .rst_n       (rst_d_n),
    .en          (en_d),
    .hcount      (hcount_d),
    .vcount      (vcount_d),
    .hsync       (hsync_d),
    .vsync       (vsync_d),
    .hblank      (hblank_d),
    .vblank      (vblank_d),
    .line_start  (ls_d),
    .frame_start (fs_d),
    .frame_cnt   (fc_d)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .H_POL    (1'b1), .V_POL (1'b1)
  ) u_dut_small (
    .clk         (clk),
    .rst_n       (rst_s_n),
    .en          (en_s),
    .hcount      (hcount_s),
    .vcount      (vcount_s),
    .hsync       (hsync_s),
    .vsync       (vsync_s),
    .hblank      (hblank_s),
    .vblank      (vblank_s),
    .line_start  (ls_s),
    .frame_start (fs_s),
    .frame_cnt   (fc_s)
  );

  // Reference timing per instance
  int ha[2]   = '{1024, 8};
  int hfp[2]  = '{24, 2};
  int hsw[2]  = '{136, 3};
  int hbp[2]  = '{160, 1};
  int va[2]   = '{768, 4};
  int vfp[2]  = '{3, 1};
  int vsw[2]  = '{6, 2};
  int vbp[2]  = '{29, 1};
  bit hpol[2] = '{1'b0, 1'b1};
  bit vpol[2] = '{1'b0, 1'b1};

  // Model state
  int mh[2], mv[2], mfc[2];
  bit mls[2], mfs[2];

  obs_t q_d[$];
  obs_t q_s[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic void model_reset(input int k);
    mh[k] = 0; mv[k] = 0; mfc[k] = 0; mls[k] = 1'b0; mfs[k] = 1'b0;
  endfunction

  function automatic void model_step(input int k, input bit en);
    int htot, vtot;
    htot = ha[k] + hfp[k] + hsw[k] + hbp[k];
    vtot = va[k] + vfp[k] + vsw[k] + vbp[k];
    mls[k] = 1'b0;
    mfs[k] = 1'b0;
    if (en) begin
      mh[k] = (mh[k] + 1) % htot;
      if (mh[k] == 0) begin
        mls[k] = 1'b1;
        mv[k]  = (mv[k] + 1) % vtot;
        if (mv[k] == 0) begin
          mfs[k] = 1'b1;
          mfc[k] = (mfc[k] + 1) % 65536;
        end
      end
    end
  endfunction

  function automatic obs_t model_out(input int k);
    obs_t e;
    bit hin, vin;
    hin  = (mh[k] >= ha[k] + hfp[k]) && (mh[k] < ha[k] + hfp[k] + hsw[k]);
    vin  = (mv[k] >= va[k] + vfp[k]) && (mv[k] < va[k] + vfp[k] + vsw[k]);
    e.h  = mh[k];
    e.v  = mv[k];
    e.hs = hin ? hpol[k] : ~hpol[k];
    e.vs = vin ? vpol[k] : ~vpol[k];
    e.hb = (mh[k] >= ha[k]);
    e.vb = (mv[k] >= va[k]);
    e.ls = mls[k];
    e.fs = mfs[k];
    e.fc = mfc[k];
    return e;
  endfunction

  function automatic void push(input int k, input obs_t e);
    if (k == 0) q_d.push_back(e);
    else        q_s.push_back(e);
  endfunction

  function automatic obs_t obs_def();
    obs_t o;
    o.h = int'(hcount_d); o.v = int'(vcount_d);
    o.hs = hsync_d; o.vs = vsync_d; o.hb = hblank_d; o.vb = vblank_d;
    o.ls = ls_d; o.fs = fs_d; o.fc = int'(fc_d);
    return o;
  endfunction

  function automatic obs_t obs_small();
    obs_t o;
    o.h = int'(hcount_s); o.v = int'(vcount_s);
    o.hs = hsync_s; o.vs = vsync_s; o.hb = hblank_s; o.vb = vblank_s;
    o.ls = ls_s; o.fs = fs_s; o.fc = int'(fc_s);
    return o;
  endfunction

  task automatic check(input string nm, input obs_t g, input obs_t e);
    n_vec++;
    if (g.h != e.h || g.v != e.v || g.hs != e.hs || g.vs != e.vs || g.hb != e.hb ||
        g.vb != e.vb || g.ls != e.ls || g.fs != e.fs || g.fc != e.fc) begin
      n_err++;
      $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b fc=%0d, want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b fc=%0d",
               nm, $time, g.h, g.v, g.hs, g.vs, g.hb, g.vb, g.ls, g.fs, g.fc,
               e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.ls, e.fs, e.fc);
    end
  endtask

  // Monitors: compare after every clock edge and right after an async reset assertion
  always @(posedge clk or negedge rst_d_n) begin
    #1;
    if (q_d.size() > 0) check("def", obs_def(), q_d.pop_front());
  end

  always @(posedge clk or negedge rst_s_n) begin
    #1;
    if (q_s.size() > 0) check("small", obs_small(), q_s.pop_front());
  end

  // One clock cycle: drive en, predict post-edge outputs, wait for next falling edge
  task automatic cyc(input bit ed, input bit es);
    en_d = ed;
    en_s = es;
    if (!rst_d_n) model_reset(0); else model_step(0, ed);
    push(0, model_out(0));
    if (!rst_s_n) model_reset(1); else model_step(1, es);
    push(1, model_out(1));
    @(negedge clk);
  endtask

  // Assert reset mid-cycle; outputs must already be at reset values 1 ns later
  task automatic async_rst(input int k);
    model_reset(k);
    push(k, model_out(k));
    if (k == 0) rst_d_n = 1'b0;
    else        rst_s_n = 1'b0;
  endtask

  function automatic bit rnd_en();
    return ($urandom_range(0, 3) != 0);
  endfunction

  initial begin
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    repeat (3) cyc(1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b1);

    // First full line on the default timing with en held high
    rst_d_n = 1'b1;
    rst_s_n = 1'b1;
    repeat (1344) cyc(1'b1, rnd_en());

    // Stall exactly at the last active pixel
    for (int i = 0; i < 2000 && mh[0] != 1023; i++) cyc(1'b1, rnd_en());
    repeat (3) cyc(1'b0, rnd_en());
    repeat (4) cyc(1'b1, rnd_en());

    // Randomized enable on both instances
    repeat (1500) cyc(rnd_en(), rnd_en());

    // Mid-line async reset of the default instance
    for (int i = 0; i < 3000 && mh[0] != 500; i++) cyc(1'b1, rnd_en());
    async_rst(0);
    repeat (2) cyc(1'b1, rnd_en());
    rst_d_n = 1'b1;
    repeat (600) cyc(rnd_en(), rnd_en());

    // Mid-frame async reset of the small instance
    for (int i = 0; i < 500 && !(mv[1] == 3 && mh[1] == 6); i++) cyc(rnd_en(), 1'b1);
    async_rst(1);
    repeat (3) cyc(rnd_en(), 1'b1);
    rst_s_n = 1'b1;

    // Many small frames: sync windows, frame pulses and frame count
    repeat (3000) cyc(rnd_en(), rnd_en());
    repeat (400) cyc(rnd_en(), 1'b1);

    en_d = 1'b0;
    en_s = 1'b0;
    repeat (3) @(negedge clk);
    if (q_d.size() != 0 || q_s.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d pending entries, want 0/0", q_d.size(), q_s.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
